cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle FSM sequencing the LEGv8 datapath one instruction at a time:
//  FETCH, DECODE, EXEC, MEM, WB. Sits beside the combinational control decoder.
//  Owns the imem/dmem request handshakes and the PC/IR/regfile write strobes.
//  Supports halt, illegal-opcode and memory-timeout traps, and counts retired instructions.
// PARAMETERS
//  MEM_TIMEOUT  64  cycles a req may wait for ready before trap; 0 = no timeout
//  CNT_W        32  width of retired_count
// PORTS
//  clk            in   1      system clock, rising edge
//  reset          in   1      asynchronous, active-high
//  inst31_21      in   11     opcode field from IR (valid from DECODE onward)
//  zero           in   1      ALU zero flag (valid in EXEC)
//  imem_req       out  1      instruction fetch request
//  imem_ready     in   1      fetch data valid this cycle
//  dmem_req       out  1      data memory request
//  dmem_we        out  1      1=store (STUR), 0=load (LDUR); qualified by dmem_req
//  dmem_ready     in   1      data access complete this cycle
//  ir_write       out  1      IR capture strobe
//  pc_write       out  1      PC update strobe
//  pc_src         out  1      0=PC+4, 1=branch target
//  reg_write      out  1      regfile write strobe
//  state_o        out  3      current state encoding
//  halted         out  1      sticky: HALT executed
//  illegal        out  1      sticky: undecodable opcode
//  timeout        out  1      sticky: memory handshake timed out
//  retired_count  out  CNT_W  instructions committed
// BEHAVIOUR
//  Reset: state=FETCH; wait_cnt, retired_count, halted, illegal, timeout = 0. While
//   reset is high, every strobe/req output is forced 0.
//  Encoding: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5 ERROR=6.
//  Decode classes (x = don't care): LDUR 11111000010, STUR 11111000000,
//   ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000,
//   ADDI 1001000100x, CBZ 10110100xxx, CBNZ 10110101xxx, B 000101xxxxx,
//   HALT 11111111111. Anything else is ILLEGAL.
//  FETCH: imem_req=1. When imem_ready=1: ir_write=1 (same cycle), next=DECODE.
//  DECODE: one cycle. Class sampled here and registered. HALT->HALT,
//   ILLEGAL->ERROR (illegal<=1), else ->EXEC.
//  EXEC: one cycle. Branch classes commit here: pc_write=1;
//   pc_src=1 for B, for CBZ when zero=1, and for CBNZ when zero=0; else 0. Next=FETCH.
//   LDUR/STUR->MEM. ALU classes->WB.
//  MEM: dmem_req=1, dmem_we=(class==STUR). On dmem_ready: LDUR->WB; STUR commits
//   (pc_write=1, pc_src=0) ->FETCH.
//  WB: reg_write=1, pc_write=1, pc_src=0, commit, next=FETCH.
//  Commit = any cycle with pc_write=1. retired_count += 1 on that edge and wraps
//   modulo 2^CNT_W.
//  All strobes are combinational from state, class and ready. Each strobe is 1 cycle.
//  Timeout: wait_cnt increments each cycle in FETCH or MEM while ready=0 and
//   clears on state change. When wait_cnt==MEM_TIMEOUT-1 with ready still 0:
//   next=ERROR, timeout<=1. A ready arriving on that same cycle wins (no trap).
//  HALT, ERROR: absorbing; all strobes 0; leave only via reset. HALT itself
//   does not count as retired.
//  Reset mid-access: req drops in the same cycle; no commit for the aborted instruction.
// STRUCTURE
//  Shared package cpu_pkg: state localparams, opcode constants/masks, class
//   enum (C_LDUR, C_STUR, C_ALU, C_ADDI, C_CBZ, C_CBNZ, C_B, C_HALT, C_ILL).
//  Sub-module cpu_opclass_decode: combinational inst31_21 -> class. Shared with
//   the control decoder.
//  Top level: state register, class register, wait_cnt, retire counter, sticky flags.
// TESTING
//  ADD (10001011000), both readys tied 1 -> FETCH,DECODE,EXEC,WB, 4 cycles;
//   reg_write and pc_write pulse in WB; retired_count=1.
//  LDUR, dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0,
//   then WB with reg_write=1; total 8 cycles.
//  CBZ, zero=1 -> pc_write=1, pc_src=1 in EXEC, 3 cycles. CBNZ, zero=1 -> pc_src=0.
//  inst31_21=00000000000 -> ERROR after DECODE, illegal=1, strobes 0 until reset.
//  MEM_TIMEOUT=4, imem_ready held 0 -> ERROR after 4 FETCH cycles, timeout=1.
//   Same run with ready asserted in cycle 4 -> no trap.
//  HALT mid-stream after 3 instructions -> halted=1, retired_count=3.
//   Reset pulse in MEM -> dmem_req=0 at once; FETCH restarts; counters = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the LEGv8 multi-cycle sequencer and the control decoder:
// state encoding, opcode patterns/masks and the instruction class enum.
package cpu_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd5,
        StError  = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        C_LDUR,
        C_STUR,
        C_ALU,
        C_ADDI,
        C_CBZ,
        C_CBNZ,
        C_B,
        C_HALT,
        C_ILL
    } opclass_e;

    localparam logic [10:0] OP_LDUR   = 11'b11111000010;
    localparam logic [10:0] OP_STUR   = 11'b11111000000;
    localparam logic [10:0] OP_ADD    = 11'b10001011000;
    localparam logic [10:0] OP_SUB    = 11'b11001011000;
    localparam logic [10:0] OP_AND    = 11'b10001010000;
    localparam logic [10:0] OP_ORR    = 11'b10101010000;
    localparam logic [10:0] OP_ADDI   = 11'b10010001000;
    localparam logic [10:0] OP_CBZ    = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ   = 11'b10110101000;
    localparam logic [10:0] OP_B      = 11'b00010100000;
    localparam logic [10:0] OP_HALT   = 11'b11111111111;

    localparam logic [10:0] MASK_FULL = 11'b11111111111;
    localparam logic [10:0] MASK_ADDI = 11'b11111111110;
    localparam logic [10:0] MASK_CB   = 11'b11111111000;
    localparam logic [10:0] MASK_B    = 11'b11111100000;

    function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat,
                                      input logic [10:0] mask);
        return (op & mask) == pat;
    endfunction

endpackage

// File: rtl/cpu_opclass_decode.sv
// Combinational opcode-field classifier; shared by the sequencer and the control decoder.
module cpu_opclass_decode
    import cpu_pkg::*;
(
    input  logic [10:0] inst31_21,
    output opclass_e    op_class
);

    always_comb begin
        op_class = C_ILL;
        if (op_match(inst31_21, OP_LDUR, MASK_FULL)) begin
            op_class = C_LDUR;
        end else if (op_match(inst31_21, OP_STUR, MASK_FULL)) begin
            op_class = C_STUR;
        end else if (op_match(inst31_21, OP_ADD, MASK_FULL) ||
                     op_match(inst31_21, OP_SUB, MASK_FULL) ||
                     op_match(inst31_21, OP_AND, MASK_FULL) ||
                     op_match(inst31_21, OP_ORR, MASK_FULL)) begin
            op_class = C_ALU;
        end else if (op_match(inst31_21, OP_ADDI, MASK_ADDI)) begin
            op_class = C_ADDI;
        end else if (op_match(inst31_21, OP_CBZ, MASK_CB)) begin
            op_class = C_CBZ;
        end else if (op_match(inst31_21, OP_CBNZ, MASK_CB)) begin
            op_class = C_CBNZ;
        end else if (op_match(inst31_21, OP_B, MASK_B)) begin
            op_class = C_B;
        end else if (op_match(inst31_21, OP_HALT, MASK_FULL)) begin
            op_class = C_HALT;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB with memory handshakes,
// commit strobes, halt/illegal/timeout traps and a retired-instruction counter.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      inst31_21,
    input  logic             zero,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             reg_write,
    output logic [2:0]       state_o,
    output logic             halted,
    output logic             illegal,
    output logic             timeout,
    output logic [CNT_W-1:0] retired_count
);

    localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit TimeoutEn = (MEM_TIMEOUT != 0);
    localparam logic [WaitW-1:0] WaitLast = TimeoutEn ? WaitW'(MEM_TIMEOUT - 1) : '0;

    state_e           state_q, state_d;
    opclass_e         class_q, class_d;
    opclass_e         dec_class;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    logic imem_req_c, dmem_req_c, dmem_we_c, ir_write_c;
    logic pc_write_c, pc_src_c, reg_write_c;
    logic waiting;

    cpu_opclass_decode u_decode (
        .inst31_21 (inst31_21),
        .op_class  (dec_class)
    );

    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        wait_d      = wait_q;
        halted_d    = halted_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        pc_src_c    = 1'b0;
        reg_write_c = 1'b0;
        waiting     = 1'b0;

        unique case (state_q)
            StFetch: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_write_c = 1'b1;
                    state_d    = StDecode;
                end else begin
                    waiting = 1'b1;
                end
            end
            StDecode: begin
                class_d = dec_class;
                unique case (dec_class)
                    C_HALT: begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end
                    C_ILL: begin
                        state_d   = StError;
                        illegal_d = 1'b1;
                    end
                    default: state_d = StExec;
                endcase
            end
            StExec: begin
                unique case (class_q)
                    C_B, C_CBZ, C_CBNZ: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = (class_q == C_B) ||
                                     (class_q == C_CBZ && zero) ||
                                     (class_q == C_CBNZ && !zero);
                        state_d    = StFetch;
                    end
                    C_LDUR, C_STUR: state_d = StMem;
                    default:        state_d = StWb;
                endcase
            end
            StMem: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (class_q == C_STUR);
                if (dmem_ready) begin
                    if (class_q == C_STUR) begin
                        pc_write_c = 1'b1;
                        state_d    = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
            StWb: begin
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                state_d     = StFetch;
            end
            StHalt, StError: ;
            default: state_d = StError;
        endcase

        // A ready on the last allowed cycle clears 'waiting', so it always beats the trap.
        if (TimeoutEn && waiting && wait_q == WaitLast) begin
            state_d   = StError;
            timeout_d = 1'b1;
        end

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (waiting) begin
            wait_d = wait_q + 1'b1;
        end

        count_d = count_q + (pc_write_c ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            class_q   <= C_ILL;
            wait_q    <= '0;
            count_q   <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Strobes are gated by reset so an in-flight request drops within the reset cycle.
    assign imem_req      = imem_req_c  & ~reset;
    assign dmem_req      = dmem_req_c  & ~reset;
    assign dmem_we       = dmem_we_c   & ~reset;
    assign ir_write      = ir_write_c  & ~reset;
    assign pc_write      = pc_write_c  & ~reset;
    assign pc_src        = pc_src_c    & ~reset;
    assign reg_write     = reg_write_c & ~reset;
    assign state_o       = state_q;
    assign halted        = halted_q;
    assign illegal       = illegal_q;
    assign timeout       = timeout_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized scoreboard bench for cpu_sequencer: a memory responder feeds instructions,
// a reference model predicts each commit, and a monitor checks commits as they appear.
module tb_cpu_sequencer;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [10:0]   inst = '0;
    logic          zero = 1'b0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write;
    logic [2:0]    state_o;
    logic          halted, illegal, timeout;
    logic [CW-1:0] retired_count;

    always #5 clk = ~clk;

    cpu_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .inst31_21     (inst),
        .zero          (zero),
        .imem_req      (imem_req),
        .imem_ready    (imem_ready),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ready    (dmem_ready),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .state_o       (state_o),
        .halted        (halted),
        .illegal       (illegal),
        .timeout       (timeout),
        .retired_count (retired_count)
    );

    // kind: 0 LDUR 1 STUR 2 ADD 3 SUB 4 AND 5 ORR 6 ADDI 7 CBZ 8 CBNZ 9 B 10 HALT 11 illegal
    typedef struct {
        int          kind;
        int          idly;
        int          ddly;
        bit          z;
        logic [10:0] op;
    } stim_t;

    typedef struct {
        int cyc;
        int dcyc;
        bit pc_src;
        bit rw;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    stim_t cur;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [10:0] enc(input int kind, input logic [31:0] r);
        case (kind)
            0:  return 11'b11111000010;
            1:  return 11'b11111000000;
            2:  return 11'b10001011000;
            3:  return 11'b11001011000;
            4:  return 11'b10001010000;
            5:  return 11'b10101010000;
            6:  return {10'b1001000100, r[0]};
            7:  return {8'b10110100, r[2:0]};
            8:  return {8'b10110101, r[2:0]};
            9:  return {6'b000101, r[4:0]};
            10: return 11'b11111111111;
            default: begin
                case (r[1:0])
                    2'd0:    return 11'b00000000000;
                    2'd1:    return 11'b11111000011;
                    2'd2:    return 11'b10010001110;
                    default: return 11'b10110110000;
                endcase
            end
        endcase
    endfunction

    // Reference model: what one instruction should look like at its commit.
    task automatic push_op(input int kind, input logic [10:0] op, input int idly,
                           input int ddly, input bit z);
        stim_t s;
        exp_t  e;
        bit    mem, wb;
        s.kind = kind; s.idly = idly; s.ddly = ddly; s.z = z; s.op = op;
        stim_q.push_back(s);
        if (kind <= 9) begin
            mem      = (kind == 0 || kind == 1);
            wb       = (kind == 0 || (kind >= 2 && kind <= 6));
            e.cyc    = (idly + 1) + 2 + (mem ? ddly + 1 : 0) + (wb ? 1 : 0);
            e.dcyc   = mem ? ddly + 1 : 0;
            e.pc_src = (kind == 9) || (kind == 7 && z) || (kind == 8 && !z);
            e.rw     = wb;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_instr(input int kind, input int idly, input int ddly, input bit z);
        push_op(kind, enc(kind, $urandom), idly, ddly, z);
    endtask

    // Memory responder: supplies the next instruction on each new fetch and answers
    // each request after the delay chosen for that instruction.
    int icnt = 0;
    int dcnt = 0;
    bit cur_valid = 1'b0;
    initial forever begin
        @(posedge clk);
        #2;
        if (reset) begin
            icnt = 0; dcnt = 0; cur_valid = 1'b0;
            imem_ready = 1'b0; dmem_ready = 1'b0;
        end else begin
            imem_ready = 1'b0;
            dmem_ready = 1'b0;
            if (imem_req) begin
                if (icnt == 0) begin
                    cur_valid = (stim_q.size() > 0);
                    if (cur_valid) begin
                        cur  = stim_q.pop_front();
                        inst = cur.op;
                        zero = cur.z;
                    end
                end
                if (cur_valid && icnt == cur.idly) begin
                    imem_ready = 1'b1;
                    icnt = 0;
                end else begin
                    icnt++;
                end
            end
            if (dmem_req) begin
                if (dcnt == cur.ddly) begin
                    dmem_ready = 1'b1;
                    dcnt = 0;
                end else begin
                    dcnt++;
                end
            end
        end
    end

    // Monitor: tracks the instruction in flight and scores each commit against the model.
    int cyc = 0, dcyc = 0, rwcnt = 0, model_cnt = 0;
    bit inprog = 1'b0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset) begin
            inprog = 1'b0;
            model_cnt = 0;
            chk("reset_strobes", {imem_req, dmem_req, ir_write, pc_write, reg_write}, 0);
        end else begin
            if (!inprog && imem_req) begin
                inprog = 1'b1; cyc = 0; dcyc = 0; rwcnt = 0;
            end
            if (inprog) begin
                cyc++;
                if (dmem_req) begin
                    dcyc++;
                    chk("dmem_we", dmem_we, cur.kind == 1);
                end
                if (reg_write) rwcnt++;
                if (ir_write) chk("ir_write_cycle", cyc, cur.idly + 1);
                if (pc_write) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_commit: got commit at cycle %0d expected none",
                                 cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("commit_cycle", cyc, e.cyc);
                        chk("dmem_cycles", dcyc, e.dcyc);
                        chk("pc_src", pc_src, e.pc_src);
                        chk("reg_write", rwcnt, e.rw);
                        chk("retired_before", retired_count, model_cnt);
                        model_cnt = (model_cnt + 1) % (1 << CW);
                    end
                    inprog = 1'b0;
                end
            end
        end
    end

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n = 0;
        while (state_o !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, state_o, st);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        stim_q.delete();
        exp_q.delete();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_state", state_o, 0);
        chk("rst_count", retired_count, 0);
        chk("rst_flags", {halted, illegal, timeout}, 0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        repeat (3) begin
            @(negedge clk);
            chk(name, {imem_req, dmem_req, ir_write, pc_write, reg_write}, 0);
        end
    endtask

    initial begin
        int n;
        // Directed spec cases followed by a random stream, terminated by HALT.
        do_reset();
        push_instr(2, 0, 0, 1'b0);
        push_instr(0, 0, 3, 1'b0);
        push_instr(7, 0, 0, 1'b1);
        push_instr(8, 0, 0, 1'b1);
        for (int i = 0; i < 36; i++) begin
            push_instr($urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)));
        end
        push_instr(10, $urandom_range(0, 3), 0, 1'b0);
        wait_state(3'd5, 2000, "halt_state");
        chk("halt_flag", halted, 1);
        chk("halt_retired", retired_count, 40 % (1 << CW));
        chk("halt_exp_empty", exp_q.size(), 0);
        chk("halt_other_flags", {illegal, timeout}, 0);
        check_quiet("halt_quiet");

        // Illegal opcode: FETCH, DECODE, then ERROR.
        do_reset();
        push_op(11, 11'b00000000000, 0, 0, 1'b0);
        @(negedge clk);
        chk("ill_fetch", state_o, 0);
        @(negedge clk);
        chk("ill_decode", state_o, 1);
        @(negedge clk);
        chk("ill_error", state_o, 6);
        chk("ill_flags", {halted, illegal, timeout}, 3'b010);
        check_quiet("ill_quiet");

        // Fetch timeout: ready on the last allowed cycle passes, one later traps.
        do_reset();
        push_instr(2, TO - 1, 0, 1'b0);
        push_instr(3, TO, 0, 1'b0);
        wait_state(3'd6, 100, "ito_state");
        chk("ito_flags", {halted, illegal, timeout}, 3'b001);
        chk("ito_retired", retired_count, 1);
        check_quiet("ito_quiet");

        // Data-memory timeout in MEM.
        do_reset();
        push_instr(0, 0, TO - 1, 1'b0);
        push_instr(1, 0, TO, 1'b0);
        wait_state(3'd6, 100, "dto_state");
        chk("dto_flags", {halted, illegal, timeout}, 3'b001);
        chk("dto_retired", retired_count, 1);

        // Reset pulse while a store is in MEM.
        do_reset();
        push_instr(2, 0, 0, 1'b0);
        push_instr(1, 1, 3, 1'b0);
        n = 0;
        while (dmem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rmem_reached", dmem_req, 1);
        chk("rmem_retired_pre", retired_count, 1);
        #1 reset = 1'b1;
        #1;
        chk("rmem_req_drop", {imem_req, dmem_req, pc_write}, 0);
        chk("rmem_state", state_o, 0);
        chk("rmem_count", retired_count, 0);
        stim_q.delete();
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        push_instr(2, 0, 0, 1'b0);
        push_instr(10, 0, 0, 1'b0);
        wait_state(3'd5, 100, "rmem_halt");
        chk("rmem_retired_post", retired_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
